// File: rtl/gate_pkg.sv
// Shared encodings, sweep state enum and FIFO entry metadata for gate_op_pipe.
// Optional: RESULT_PARITY_EN adds a per-entry parity bit.
package gate_pkg;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_NAND = 3'd2;
    localparam logic [2:0] OP_NOR  = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;

    localparam int unsigned SWEEP_LEN = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    // Result is WIDTH-dependent, so the top wraps this with its own result field.
    typedef struct packed {
        logic       err;
        logic       src;
        logic [1:0] idx;
`ifdef RESULT_PARITY_EN
        logic       parity;
`endif
    } entry_meta_t;

    function automatic logic is_reserved(input logic [2:0] op);
        return op > OP_XNOR;
    endfunction

endpackage

// File: rtl/gate_fifo.sv
// Entry-width agnostic FIFO with occupancy output; head data reads as zero when empty.
module gate_fifo #(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned ENTRYW = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [ENTRYW-1:0]            wdata,
    input  logic                         pop_ready,
    output logic [ENTRYW-1:0]            rdata,
    output logic                         valid,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int unsigned PTRW = $clog2(DEPTH);
    localparam int unsigned LVLW = $clog2(DEPTH+1);

    logic [ENTRYW-1:0] mem [DEPTH];
    logic [PTRW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [LVLW-1:0]   level_q;
    logic              pop;

    assign valid = (level_q != '0);
    assign full  = (level_q == LVLW'(DEPTH));
    assign level = level_q;
    assign pop   = valid && pop_ready;
    assign rdata = valid ? mem[rd_ptr_q] : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    // DEPTH is a power of two, so plain increment wraps the pointers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTRW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTRW'(1);
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + LVLW'(1);
                2'b01:   level_q <= level_q - LVLW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/gate_op_pipe.sv
// Registered bitwise gate unit with output FIFO and truth-table sweep FSM.
// Optional: RESULT_PARITY_EN adds out_parity (stored parity of the head result).
module gate_op_pipe
    import gate_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             a,
    input  logic [WIDTH-1:0]             b,
    input  logic [2:0]                   op,
    input  logic                         inv_a,
    input  logic                         inv_b,
    input  logic                         sweep_start,
    output logic                         sweep_busy,
    output logic                         sweep_done,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             result,
    output logic                         out_err,
    output logic                         out_src,
    output logic [1:0]                   out_idx,
`ifdef RESULT_PARITY_EN
    output logic                         out_parity,
`endif
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    typedef struct packed {
        logic [WIDTH-1:0] result;
        entry_meta_t      meta;
    } entry_t;

    localparam int unsigned ENTRYW = $bits(entry_t);

    state_e      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [2:0]  op_q;
    logic        inv_a_q, inv_b_q;
    logic        latch;
    logic        push;
    logic        full;

    logic [2:0]       sel_op;
    logic             sel_ia, sel_ib;
    logic [WIDTH-1:0] opnd_a, opnd_b, xa, xb, gate_res;
    entry_t           w_entry, head;
    logic [ENTRYW-1:0] rdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            op_q    <= '0;
            inv_a_q <= 1'b0;
            inv_b_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (latch) begin
                op_q    <= op;
                inv_a_q <= inv_a;
                inv_b_q <= inv_b;
            end
        end
    end

    // sweep_start wins over in_valid in IDLE, so no operand transfer on the start cycle.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        latch   = 1'b0;
        push    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (sweep_start) begin
                    state_d = RUN;
                    idx_d   = '0;
                    latch   = 1'b1;
                end else if (in_valid && !full) begin
                    push = 1'b1;
                end
            end
            RUN: begin
                if (!full) begin
                    push = 1'b1;
                    if (idx_q == 2'(SWEEP_LEN - 1)) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sel_op = op;
        sel_ia = inv_a;
        sel_ib = inv_b;
        opnd_a = a;
        opnd_b = b;
        if (state_q == RUN) begin
            sel_op = op_q;
            sel_ia = inv_a_q;
            sel_ib = inv_b_q;
            opnd_a = {WIDTH{idx_q[1]}};
            opnd_b = {WIDTH{idx_q[0]}};
        end
        xa = sel_ia ? ~opnd_a : opnd_a;
        xb = sel_ib ? ~opnd_b : opnd_b;
        case (sel_op)
            OP_AND:  gate_res = xa & xb;
            OP_OR:   gate_res = xa | xb;
            OP_NAND: gate_res = ~(xa & xb);
            OP_NOR:  gate_res = ~(xa | xb);
            OP_XOR:  gate_res = xa ^ xb;
            OP_XNOR: gate_res = ~(xa ^ xb);
            default: gate_res = '0;
        endcase
        w_entry          = '0;
        w_entry.result   = gate_res;
        w_entry.meta.err = is_reserved(sel_op);
        w_entry.meta.src = (state_q == RUN);
        w_entry.meta.idx = (state_q == RUN) ? idx_q : 2'd0;
`ifdef RESULT_PARITY_EN
        w_entry.meta.parity = ^gate_res;
`endif
    end

    gate_fifo #(
        .DEPTH  (DEPTH),
        .ENTRYW (ENTRYW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .wdata     (w_entry),
        .pop_ready (out_ready),
        .rdata     (rdata),
        .valid     (out_valid),
        .full      (full),
        .level     (level)
    );

    assign head       = rdata;
    assign result     = head.result;
    assign out_err    = head.meta.err;
    assign out_src    = head.meta.src;
    assign out_idx    = head.meta.idx;
`ifdef RESULT_PARITY_EN
    assign out_parity = head.meta.parity;
`endif

    assign in_ready   = !full && (state_q == IDLE);
    assign sweep_busy = (state_q == RUN);
    assign sweep_done = (state_q == DONE);

endmodule

// File: tb/tb_gate_op_pipe.sv
// Self-checking bench for gate_op_pipe: fixed vectors, hand sequences and a
// random run compared against a queue-based reference model.
module tb_gate_op_pipe;

    localparam int W  = 8;
    localparam int D  = 2;
    localparam int LW = $clog2(D + 1);

    logic          clk = 1'b0;
    logic          rst_n, in_valid, in_ready, inv_a, inv_b, sweep_start;
    logic          sweep_busy, sweep_done, out_valid, out_ready, out_err, out_src;
    logic [W-1:0]  a, b, result;
    logic [2:0]    op;
    logic [1:0]    out_idx;
    logic [LW-1:0] level;
`ifdef RESULT_PARITY_EN
    logic          out_parity;
`endif

    always #5 clk = ~clk;

    gate_op_pipe #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .inv_a(inv_a), .inv_b(inv_b),
        .sweep_start(sweep_start), .sweep_busy(sweep_busy), .sweep_done(sweep_done),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .out_err(out_err), .out_src(out_src), .out_idx(out_idx),
`ifdef RESULT_PARITY_EN
        .out_parity(out_parity),
`endif
        .level(level)
    );

    typedef struct {
        logic [W-1:0] res;
        bit           err;
        bit           src;
        logic [1:0]   idx;
    } exp_t;

    typedef struct {
        logic [W-1:0] a, b;
        logic [2:0]   op;
        bit           ia, ib;
        logic [W-1:0] res;
        bit           err;
    } vec_t;

    exp_t         q[$];
    bit           m_busy, m_done, m_ia, m_ib;
    int           m_i;
    logic [2:0]   m_op;
    int           n_checks, n_errors;

    logic [W-1:0] got_res[$];
    logic [1:0]   got_idx[$];
    bit           got_src[$];
    int           cnt_done, cnt_nr;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
        end
    endfunction

    function automatic exp_t ref_gate(input logic [2:0] o, input logic [W-1:0] x,
                                      input logic [W-1:0] y, input bit ia, input bit ib,
                                      input bit src, input logic [1:0] idx);
        exp_t e;
        logic [W-1:0] p, r;
        p = ia ? ~x : x;
        r = ib ? ~y : y;
        e.err = 1'b0;
        case (o)
            3'd0: e.res = p & r;
            3'd1: e.res = p | r;
            3'd2: e.res = ~(p & r);
            3'd3: e.res = ~(p | r);
            3'd4: e.res = p ^ r;
            3'd5: e.res = ~(p ^ r);
            default: begin e.res = '0; e.err = 1'b1; end
        endcase
        e.src = src;
        e.idx = idx;
        return e;
    endfunction

    // Compare DUT against the model, advance the model over the coming edge, then step.
    task automatic cycle();
        exp_t e, pe;
        bit   full, pop, have_push;
        full = (q.size() == D);
        chk("in_ready", 32'(in_ready), 32'(!full && !m_busy && !m_done));
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("level", 32'(level), 32'(q.size()));
        chk("sweep_busy", 32'(sweep_busy), 32'(m_busy));
        chk("sweep_done", 32'(sweep_done), 32'(m_done));
        if (q.size() != 0) e = q[0];
        else e = '{res: '0, err: 1'b0, src: 1'b0, idx: 2'd0};
        chk("result", 32'(result), 32'(e.res));
        chk("out_err", 32'(out_err), 32'(e.err));
        chk("out_src", 32'(out_src), 32'(e.src));
        chk("out_idx", 32'(out_idx), 32'(e.idx));
`ifdef RESULT_PARITY_EN
        chk("out_parity", 32'(out_parity), 32'(^e.res));
`endif
        pop = (q.size() != 0) && out_ready;
        have_push = 1'b0;
        pe = e;
        if (!rst_n) begin
            q.delete();
            m_busy = 1'b0;
            m_done = 1'b0;
            m_i = 0;
        end else begin
            if (m_done) begin
                m_done = 1'b0;
            end else if (m_busy) begin
                if (!full) begin
                    have_push = 1'b1;
                    pe = ref_gate(m_op, (m_i >= 2) ? {W{1'b1}} : {W{1'b0}},
                                  (m_i % 2 == 1) ? {W{1'b1}} : {W{1'b0}},
                                  m_ia, m_ib, 1'b1, 2'(m_i));
                    if (m_i == 3) begin m_busy = 1'b0; m_done = 1'b1; end
                    else m_i++;
                end
            end else if (sweep_start) begin
                m_busy = 1'b1;
                m_i = 0;
                m_op = op; m_ia = inv_a; m_ib = inv_b;
            end else if (in_valid && !full) begin
                have_push = 1'b1;
                pe = ref_gate(op, a, b, inv_a, inv_b, 1'b0, 2'd0);
            end
            if (pop) void'(q.pop_front());
            if (have_push) q.push_back(pe);
        end
        @(posedge clk);
        #1;
    endtask

    // Runs a sweep with sweep_start held for nstart cycles, recording what is popped.
    task automatic run_sweep(input int nstart, input int ncyc);
        got_res.delete(); got_idx.delete(); got_src.delete();
        cnt_done = 0;
        cnt_nr = 0;
        for (int c = 0; c < ncyc; c++) begin
            sweep_start = (c < nstart);
            if (out_valid && out_ready) begin
                got_res.push_back(result);
                got_idx.push_back(out_idx);
                got_src.push_back(out_src);
            end
            if (sweep_done) cnt_done++;
            if (sweep_busy && !in_ready) cnt_nr++;
            cycle();
        end
        sweep_start = 1'b0;
    endtask

    vec_t vt[9];
    logic [W-1:0] sw_nand[4];
    logic [W-1:0] sw_xorb[4];

    initial begin
        n_checks = 0; n_errors = 0;
        m_busy = 0; m_done = 0; m_i = 0; m_op = '0; m_ia = 0; m_ib = 0;
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; op = '0;
        inv_a = 1'b0; inv_b = 1'b0; sweep_start = 1'b0; out_ready = 1'b0;

        vt[0] = '{8'hF0, 8'hCC, 3'd2, 1'b0, 1'b0, 8'h3F, 1'b0};
        vt[1] = '{8'h00, 8'hFF, 3'd2, 1'b1, 1'b0, 8'h00, 1'b0};
        vt[2] = '{8'hF0, 8'hCC, 3'd0, 1'b0, 1'b0, 8'hC0, 1'b0};
        vt[3] = '{8'hF0, 8'hCC, 3'd1, 1'b0, 1'b0, 8'hFC, 1'b0};
        vt[4] = '{8'hF0, 8'hCC, 3'd3, 1'b0, 1'b0, 8'h03, 1'b0};
        vt[5] = '{8'hF0, 8'hCC, 3'd4, 1'b0, 1'b0, 8'h3C, 1'b0};
        vt[6] = '{8'hF0, 8'hCC, 3'd5, 1'b0, 1'b1, 8'h3C, 1'b0};
        vt[7] = '{8'hFF, 8'hFF, 3'd7, 1'b0, 1'b0, 8'h00, 1'b1};
        vt[8] = '{8'h5A, 8'hA5, 3'd6, 1'b0, 1'b0, 8'h00, 1'b1};
        sw_nand = '{8'hFF, 8'hFF, 8'hFF, 8'h00};
        sw_xorb = '{8'hFF, 8'h00, 8'h00, 8'hFF};

        // Reset held for three edges.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_sweep_busy", 32'(sweep_busy), 32'd0);
        chk("rst_sweep_done", 32'(sweep_done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        rst_n = 1'b1;
        cycle();
        chk("in_ready_after_rst", 32'(in_ready), 32'd1);

        // Fixed vectors, one transfer each, checked against constants.
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            a = vt[i].a; b = vt[i].b; op = vt[i].op;
            inv_a = vt[i].ia; inv_b = vt[i].ib;
            in_valid = 1'b1;
            cycle();
            in_valid = 1'b0;
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("vec%0d_result", i), 32'(result), 32'(vt[i].res));
            chk($sformatf("vec%0d_err", i), 32'(out_err), 32'(vt[i].err));
            chk($sformatf("vec%0d_src", i), 32'(out_src), 32'd0);
            cycle();
        end
        inv_a = 1'b0; inv_b = 1'b0;

        // NAND sweep; in_valid high on the start cycle must not be taken.
        op = 3'd2; a = 8'h12; b = 8'h34; in_valid = 1'b1;
        sweep_start = 1'b1;
        cycle();
        in_valid = 1'b0;
        run_sweep(0, 9);
        chk("sweep1_count", 32'(got_res.size()), 32'd4);
        for (int i = 0; i < 4 && i < got_res.size(); i++) begin
            chk($sformatf("sweep1_res%0d", i), 32'(got_res[i]), 32'(sw_nand[i]));
            chk($sformatf("sweep1_idx%0d", i), 32'(got_idx[i]), 32'(i));
            chk($sformatf("sweep1_src%0d", i), 32'(got_src[i]), 32'd1);
        end
        chk("sweep1_done_once", 32'(cnt_done), 32'd1);
        chk("sweep1_ready_low", 32'(cnt_nr), 32'd4);

        // XOR with inverted B; sweep_start held into RUN is ignored.
        op = 3'd4; inv_b = 1'b1;
        run_sweep(3, 10);
        inv_b = 1'b0;
        chk("sweep2_count", 32'(got_res.size()), 32'd4);
        for (int i = 0; i < 4 && i < got_res.size(); i++)
            chk($sformatf("sweep2_res%0d", i), 32'(got_res[i]), 32'(sw_xorb[i]));
        chk("sweep2_done_once", 32'(cnt_done), 32'd1);

        // Backpressure: fill, hold head, drain in order.
        out_ready = 1'b0; op = 3'd1; b = 8'h00; in_valid = 1'b1;
        a = 8'h01; cycle();
        a = 8'h02; cycle();
        in_valid = 1'b0;
        chk("bp_level", 32'(level), 32'd2);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_head", 32'(result), 32'h01);
        cycle();
        chk("bp_head_stable", 32'(result), 32'h01);
        out_ready = 1'b1;
        chk("bp_first", 32'(result), 32'h01);
        cycle();
        chk("bp_second", 32'(result), 32'h02);
        cycle();
        // Simultaneous push and pop at level 1.
        out_ready = 1'b0; a = 8'h55; in_valid = 1'b1;
        cycle();
        out_ready = 1'b1; a = 8'hAA;
        cycle();
        in_valid = 1'b0;
        chk("pp_level", 32'(level), 32'd1);
        chk("pp_head", 32'(result), 32'hAA);
        cycle();

        // Reset while the sweep is stalled at idx 2 behind a full FIFO.
        out_ready = 1'b0; op = 3'd2;
        sweep_start = 1'b1;
        cycle();
        sweep_start = 1'b0;
        cycle();
        cycle();
        chk("mid_level", 32'(level), 32'd2);
        chk("mid_busy", 32'(sweep_busy), 32'd1);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        chk("abort_level", 32'(level), 32'd0);
        chk("abort_busy", 32'(sweep_busy), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        cnt_done = 0;
        for (int i = 0; i < 4; i++) begin
            if (sweep_done) cnt_done++;
            cycle();
        end
        chk("abort_no_done", 32'(cnt_done), 32'd0);
        out_ready = 1'b1;
        run_sweep(1, 9);
        chk("restart_count", 32'(got_res.size()), 32'd4);
        if (got_idx.size() != 0) chk("restart_idx0", 32'(got_idx[0]), 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rst_n       = ($urandom_range(0, 299) != 0);
            in_valid    = $urandom_range(0, 1) == 1;
            a           = W'($urandom);
            b           = W'($urandom);
            op          = 3'($urandom_range(0, 7));
            inv_a       = $urandom_range(0, 1) == 1;
            inv_b       = $urandom_range(0, 1) == 1;
            sweep_start = ($urandom_range(0, 19) == 0);
            out_ready   = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
